// File: rtl/seq_log_pkg.sv
// Shared defaults and types for the sequence-detector event logger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seq_log_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;

    typedef logic [TS_W_DEF-1:0] stamp_t;

endpackage

// File: rtl/seq_event_logger_if.sv
// Detector/consumer side bundle of the event logger; clr_ovf/overflow exist only with SEQ_LOG_OVF_EN.
// Latency: n/a (wires only).
// Backpressure: consumer pops with rd_en; hits are never stalled, only dropped when full.
interface seq_event_logger_if
    import seq_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             hit;
    logic             rd_en;
    logic             evt_valid;
    logic [TS_W-1:0]  evt_stamp;
    logic [LVL_W-1:0] level;
    logic             full;
    logic [CNT_W-1:0] hit_count;
`ifdef SEQ_LOG_OVF_EN
    logic             clr_ovf;
    logic             overflow;

    modport master (
        output hit, rd_en, clr_ovf,
        input  evt_valid, evt_stamp, level, full, hit_count, overflow
    );
    modport slave (
        input  hit, rd_en, clr_ovf,
        output evt_valid, evt_stamp, level, full, hit_count, overflow
    );
`else
    modport master (
        output hit, rd_en,
        input  evt_valid, evt_stamp, level, full, hit_count
    );
    modport slave (
        input  hit, rd_en,
        output evt_valid, evt_stamp, level, full, hit_count
    );
`endif

endinterface

// File: rtl/seq_log_fifo.sv
// Circular event store: synchronous write, show-ahead read, occupancy and full flag.
// Latency: a push is visible at the head one cycle later; head data is combinational from storage.
// Backpressure: pop ignored when empty; push dropped when full unless a pop frees a slot that cycle.
module seq_log_fifo #(
    parameter int DEPTH = 8,
    parameter int DAT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_push_vld,
    input  logic [DAT_W-1:0]       i_push_dat,
    input  logic                   i_pop_rdy,
    output logic                   o_pop_vld,
    output logic [DAT_W-1:0]       o_pop_dat,
    output logic [$clog2(DEPTH):0] o_level,
    output logic                   o_full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [DAT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [LVL_W-1:0] r_level;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == LVL_W'(DEPTH));
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign w_pop   = i_pop_rdy && !w_empty;
    assign w_push  = i_push_vld && (!w_full || w_pop);

    assign o_pop_vld = !w_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_level   = r_level;
    assign o_full    = w_full;

    // Storage write; contents need no reset because occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks net push/pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/seq_event_logger.sv
// Timestamps detector hits into a FIFO and counts them (saturating); overflow flag under SEQ_LOG_OVF_EN.
// Latency: a hit appears on evt_valid/evt_stamp the next cycle, stamped with that cycle's ts.
// Backpressure: consumer pops via rd_en; hits arriving while full with no pop are dropped.
module seq_event_logger
    import seq_log_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int TS_W  = TS_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    seq_event_logger_if.slave   bus
);
    logic [TS_W-1:0]  r_ts;
    logic [CNT_W-1:0] r_hit_cnt;

    seq_log_fifo #(
        .DEPTH (DEPTH),
        .DAT_W (TS_W)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_push_vld (bus.hit),
        .i_push_dat (r_ts),
        .i_pop_rdy  (bus.rd_en),
        .o_pop_vld  (bus.evt_valid),
        .o_pop_dat  (bus.evt_stamp),
        .o_level    (bus.level),
        .o_full     (bus.full)
    );

    assign bus.hit_count = r_hit_cnt;

    // Free-running timestamp; zero in reset so the first edge after release stamps 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ts <= '0;
        end else begin
            r_ts <= r_ts + TS_W'(1);
        end
    end

    // Every hit counts, including ones the FIFO drops; holds at all-ones.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hit_cnt <= '0;
        end else if (bus.hit && (r_hit_cnt != {CNT_W{1'b1}})) begin
            r_hit_cnt <= r_hit_cnt + CNT_W'(1);
        end
    end

`ifdef SEQ_LOG_OVF_EN
    logic w_drop;
    logic r_ovf;

    assign w_drop       = bus.hit && bus.full && !(bus.rd_en && bus.evt_valid);
    assign bus.overflow = r_ovf;

    // Sticky drop flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (bus.clr_ovf) begin
            r_ovf <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_seq_event_logger.sv
// Self-checking bench for seq_event_logger with a queue scoreboard of expected stamps.
// Latency: n/a.
// Backpressure: n/a.
module tb_seq_event_logger;
    import seq_log_pkg::*;

    localparam int DEPTH = DEPTH_DEF;
    localparam int TS_W  = TS_W_DEF;
    localparam int CNT_W = CNT_W_DEF;

    logic clk;
    logic reset;

    seq_event_logger_if #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) bus ();

    seq_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    stamp_t           m_ts;
    stamp_t           sb[$];
    logic [CNT_W-1:0] m_cnt;
    logic             m_ovf;
    int               n_chk;
    int               n_pass;

    // Independent timestamp model: zero in reset, +1 per rising edge.
    always @(posedge clk or negedge reset) begin
        if (!reset) m_ts <= '0;
        else        m_ts <= m_ts + 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic check_state();
        chk("evt_valid", 32'(bus.evt_valid), 32'(sb.size() != 0));
        chk("level", 32'(bus.level), 32'(sb.size()));
        chk("full", 32'(bus.full), 32'(sb.size() == DEPTH));
        chk("hit_count", 32'(bus.hit_count), 32'(m_cnt));
        if (sb.size() != 0) chk("head_stamp", 32'(bus.evt_stamp), 32'(sb[0]));
`ifdef SEQ_LOG_OVF_EN
        chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`endif
    endtask

    // Called at a falling edge: drive one cycle of stimulus, update the model, check after the next rise.
    task automatic step(input logic h, input logic r, input logic c);
        int     n;
        logic   popped;
        logic   pushed;
        stamp_t exp;
        bus.hit   = h;
        bus.rd_en = r;
`ifdef SEQ_LOG_OVF_EN
        bus.clr_ovf = c;
`endif
        n      = sb.size();
        popped = r && (n != 0);
        pushed = h && ((n < DEPTH) || popped);
        if (popped) begin
            exp = sb.pop_front();
            chk("pop_stamp", 32'(bus.evt_stamp), 32'(exp));
        end
        if (pushed) sb.push_back(m_ts);
        if (h && (m_cnt != {CNT_W{1'b1}})) m_cnt = m_cnt + 1'b1;
        if (h && !pushed) m_ovf = 1'b1;
        else if (c)       m_ovf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.hit   = 1'b0;
        bus.rd_en = 1'b0;
`ifdef SEQ_LOG_OVF_EN
        bus.clr_ovf = 1'b0;
`endif
        check_state();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Asynchronous reset mid-cycle: state must clear at once, and nothing completes under reset.
    task automatic do_reset();
        #1;
        reset = 1'b0;
        sb.delete();
        m_cnt = '0;
        m_ovf = 1'b0;
        #1;
        check_state();
        bus.hit   = 1'b1;
        bus.rd_en = 1'b1;
        @(negedge clk);
        check_state();
        chk("ts_in_reset", 32'(dut.r_ts), 32'(0));
        bus.hit   = 1'b0;
        bus.rd_en = 1'b0;
        reset     = 1'b1;
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        m_cnt     = '0;
        m_ovf     = 1'b0;
        reset     = 1'b0;
        bus.hit   = 1'b0;
        bus.rd_en = 1'b0;
`ifdef SEQ_LOG_OVF_EN
        bus.clr_ovf = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check_state();
        reset = 1'b1;

        // Hit at ts=5 right after reset release
        while (m_ts != 16'd5) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        chk("first_stamp", 32'(bus.evt_stamp), 32'd5);

        // Hits at 3,4,10 then drain in order, then read while empty
        @(negedge clk);
        do_reset();
        while (m_ts != 16'd3) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        while (m_ts != 16'd10) step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) step(1'b0, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);

        // Fill past DEPTH, overflow set/clear and set-over-clear priority
        repeat (DEPTH + 1) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);

        // Push and pop together while full, then drain and push+pop while empty
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        repeat (DEPTH) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Counter saturation with random consumer activity
        repeat (300) step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("hit_count_sat", 32'(bus.hit_count), 32'd255);

        // Timestamp wrap, then reset with three entries held
        do_reset();
        while (m_ts != 16'hFFFF) tick();
        repeat (4) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        chk("wrap_head", 32'(bus.evt_stamp), 32'd0);
        do_reset();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
